pll_lock_supervisor: RTL

//  Sequences the 2-output system PLL (2 MHz / 0.7 MHz from 50 MHz refclk): drives its reset, qualifies lock,

---
 rtl/pll_sup_pkg.sv | 22 ++
 rtl/sync_2ff.sv | 15 +
 rtl/pll_lock_supervisor.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/pll_sup_pkg.sv
// Shared definitions for the PLL lock supervisor: FSM state encoding and
// the width of the relock event counter.
package pll_sup_pkg;

    typedef enum logic [2:0] {
        ST_RESET_PLL = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_REL0      = 3'd3,
        ST_REL1      = 3'd4,
        ST_RUN       = 3'd5,
        ST_FAULT     = 3'd6
    } pll_state_e;

    localparam int RELOCK_W = 8;

    // States in which the lock-acquisition timeout window is running
    function automatic logic in_lock_window(input pll_state_e s);
        return (s == ST_WAIT_LOCK) || (s == ST_STABLE);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Reset-less two-flop synchroniser for a single asynchronous level.
module sync_2ff (
    input  logic clk,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        meta <= d;
        q    <= meta;
    end

endmodule

// File: rtl/pll_lock_supervisor.sv
// Sequences the system PLL reset, qualifies lock, releases the two downstream
// domain resets in order and recovers from lock loss with bounded retries.
//
// state      | meaning
// RESET_PLL  | pll_rst held high for RST_CYCLES
// WAIT_LOCK  | pll_rst low, waiting for synchronised lock
// STABLE     | lock must stay high STABLE_CYCLES in a row
// REL0       | sys_rst_0 released, waiting RELEASE_GAP
// REL1       | sys_rst_1 released for one cycle
// RUN        | both domains out of reset, ready high
// FAULT      | retries exhausted, waits for sw_relock
module pll_lock_supervisor
    import pll_sup_pkg::*;
#(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 50000,
    parameter int STABLE_CYCLES = 1024,
    parameter int RELEASE_GAP   = 64,
    parameter int MAX_RETRIES   = 3,
    parameter int CNT_W         = 16
) (
    input  logic                refclk,
    input  logic                rst,
    input  logic                pll_locked,
    input  logic                sw_relock,
    output logic                pll_rst,
    output logic                sys_rst_0,
    output logic                sys_rst_1,
    output logic                ready,
    output logic                fault,
    output logic [RELOCK_W-1:0] relock_count,
    output logic [2:0]          state_o
);

    localparam int RETRY_W = $clog2(MAX_RETRIES + 1);

    localparam logic [CNT_W-1:0]    T_LAST      = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]    S_LAST      = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]    RST_LAST    = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]    GAP_LAST    = CNT_W'(RELEASE_GAP - 1);
    localparam logic [RETRY_W-1:0]  RETRY_LIMIT = RETRY_W'(MAX_RETRIES);
    localparam logic [RELOCK_W-1:0] RELOCK_MAX  = '1;

    if (2 ** CNT_W <= LOCK_TIMEOUT) begin : g_bad_cnt_w
        $error("CNT_W too narrow for LOCK_TIMEOUT");
    end
    if (STABLE_CYCLES >= LOCK_TIMEOUT) begin : g_bad_stable
        $error("LOCK_TIMEOUT must exceed STABLE_CYCLES");
    end

    pll_state_e           state;
    pll_state_e           next_state;
    logic                 locked_s;
    logic [CNT_W-1:0]     t_cnt;
    logic [CNT_W-1:0]     s_cnt;
    logic [CNT_W-1:0]     g_cnt;
    logic [RETRY_W-1:0]   retries;
    logic [RETRY_W-1:0]   retries_next;
    logic                 lock_lost;
    logic                 pll_rst_d;
    logic                 sys_rst_0_d;
    logic                 sys_rst_1_d;
    logic                 ready_d;
    logic                 fault_d;

    sync_2ff u_lock_sync (
        .clk (refclk),
        .d   (pll_locked),
        .q   (locked_s)
    );

    always_ff @(posedge refclk) begin
        if (rst) begin
            state     <= ST_RESET_PLL;
            pll_rst   <= 1'b1;
            sys_rst_0 <= 1'b1;
            sys_rst_1 <= 1'b1;
            ready     <= 1'b0;
            fault     <= 1'b0;
        end else begin
            state     <= next_state;
            pll_rst   <= pll_rst_d;
            sys_rst_0 <= sys_rst_0_d;
            sys_rst_1 <= sys_rst_1_d;
            ready     <= ready_d;
            fault     <= fault_d;
        end
    end

    // sw_relock outranks timeout and lock loss; timeout outranks lock qualification
    always_comb begin
        next_state   = state;
        retries_next = retries;
        lock_lost    = 1'b0;
        if (sw_relock) begin
            next_state   = ST_RESET_PLL;
            retries_next = '0;
        end else begin
            unique case (state)
                ST_RESET_PLL: begin
                    if (g_cnt == RST_LAST) next_state = ST_WAIT_LOCK;
                end
                ST_WAIT_LOCK, ST_STABLE: begin
                    if (t_cnt == T_LAST) begin
                        retries_next = retries + 1'b1;
                        next_state   = (retries_next == RETRY_LIMIT) ? ST_FAULT : ST_RESET_PLL;
                    end else if (state == ST_WAIT_LOCK) begin
                        if (locked_s) next_state = ST_STABLE;
                    end else if (!locked_s) begin
                        next_state = ST_WAIT_LOCK;
                    end else if (s_cnt == S_LAST) begin
                        next_state = ST_REL0;
                    end
                end
                ST_REL0, ST_REL1, ST_RUN: begin
                    if (!locked_s) begin
                        lock_lost  = 1'b1;
                        next_state = ST_RESET_PLL;
                    end else if (state == ST_REL1) begin
                        next_state   = ST_RUN;
                        retries_next = '0;
                    end else if (state == ST_REL0 && g_cnt == GAP_LAST) begin
                        next_state = ST_REL1;
                    end
                end
                ST_FAULT: next_state = ST_FAULT;
                default:  next_state = ST_RESET_PLL;
            endcase
        end
    end

    always_comb begin
        pll_rst_d   = (next_state == ST_RESET_PLL) || (next_state == ST_FAULT);
        sys_rst_0_d = !((next_state == ST_REL0) || (next_state == ST_REL1) || (next_state == ST_RUN));
        sys_rst_1_d = !((next_state == ST_REL1) || (next_state == ST_RUN));
        ready_d     = (next_state == ST_RUN);
        fault_d     = (next_state == ST_FAULT);
    end

    // The timeout window survives STABLE->WAIT_LOCK so a flapping lock still times out
    always_ff @(posedge refclk) begin
        if (rst) begin
            t_cnt        <= '0;
            s_cnt        <= '0;
            g_cnt        <= '0;
            retries      <= '0;
            relock_count <= '0;
        end else begin
            t_cnt   <= (in_lock_window(state) && in_lock_window(next_state)) ? t_cnt + 1'b1 : '0;
            s_cnt   <= (state == ST_STABLE && next_state == ST_STABLE) ? s_cnt + 1'b1 : '0;
            g_cnt   <= (!sw_relock && state == next_state &&
                        (state == ST_RESET_PLL || state == ST_REL0)) ? g_cnt + 1'b1 : '0;
            retries <= retries_next;
            if (lock_lost && relock_count != RELOCK_MAX) relock_count <= relock_count + 1'b1;
        end
    end

    assign state_o = state;

endmodule
